// File: rtl/pc_gen_pkg.sv
// Shared Saratoga fetch-stage constants and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_gen_pkg;

  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam int          IALIGN_DEFAULT     = 32;

  // Ceiling log2 for sizing pointers; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, oldest entry overwritten when full.
// Latency: push/pop take effect at the next edge; top is the registered entry.
// Backpressure: none; pop on an empty stack is ignored.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef logic [PW-1:0] ras_ptr_t;

  logic [XLEN-1:0] mem_q [DEPTH];
  ras_ptr_t        ptr_q, ptr_d, wr_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic            do_pop;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign top    = mem_q[ptr_q];
  assign do_pop = pop && !empty;

  // Pointer/count update; push+pop together replaces the top in place.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    case ({push, do_pop})
      2'b10: begin
        ptr_d  = ptr_q + 1'b1;
        cnt_d  = full ? cnt_q : cnt_q + 1'b1;
        wr_en  = 1'b1;
        wr_idx = ptr_q + 1'b1;
      end
      2'b01: begin
        ptr_d = ptr_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
      2'b11: begin
        wr_en  = 1'b1;
        wr_idx = ptr_q;
      end
      default: ;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: prioritised redirects, stall, RAS return prediction.
// Latency: 1 cycle from sampled inputs to pc; all outputs registered.
// Backpressure: stall_fetch holds pc, but any redirect still overrides it.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_ADDR   = XLEN'(DEFAULT_RESET_ADDR),
  parameter int              NUM_REDIRECT = 3,
  parameter int              RAS_DEPTH    = 4,
  parameter int              IALIGN       = IALIGN_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall_fetch,
  input  logic [NUM_REDIRECT-1:0]            redirect_en,
  input  logic [NUM_REDIRECT-1:0][XLEN-1:0]  redirect_pc,
  input  logic                               inst_len16,
  input  logic                               call,
  input  logic                               ret,
  output logic [XLEN-1:0]                    pc,
  output logic                               pc_valid,
  output logic                               misalign,
  output logic [XLEN-1:0]                    misalign_addr,
  output logic                               ras_empty
);

  // Low address bits that must be zero for a legal fetch address.
  localparam int              AB    = (IALIGN == 16) ? 1 : 2;
  localparam logic [XLEN-1:0] AMASK = XLEN'((1 << AB) - 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] maddr_q, maddr_d;

  logic            rd_hit;
  logic [XLEN-1:0] rd_tgt;
  logic [XLEN-1:0] step, seq;
  logic            ras_push, ras_pop;
  logic [XLEN-1:0] ras_top;
  logic            unused_ras_full;

  // Redirect priority encoder: scan high to low so the lowest index wins.
  always_comb begin
    rd_hit = 1'b0;
    rd_tgt = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (redirect_en[i]) begin
        rd_hit = 1'b1;
        rd_tgt = redirect_pc[i];
      end
    end
  end

  assign step = (IALIGN == 16 && inst_len16) ? XLEN'(2) : XLEN'(4);
  assign seq  = pc_q + step;

  // Next-PC selection: redirect > stall > RAS-predicted return > sequential.
  always_comb begin
    pc_d     = pc_q;
    mis_d    = 1'b0;
    maddr_d  = maddr_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (rd_hit) begin
      pc_d = rd_tgt & ~AMASK;
      if ((rd_tgt & AMASK) != '0) begin
        mis_d   = 1'b1;
        maddr_d = rd_tgt;
      end
    end else if (stall_fetch) begin
      pc_d = pc_q;
    end else if (ret && !ras_empty) begin
      pc_d     = ras_top;
      ras_pop  = 1'b1;
      ras_push = call;
    end else begin
      pc_d     = seq;
      ras_push = call;
    end
  end

  // Architectural PC and misalign reporting registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_ADDR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      mis_q   <= mis_d;
      maddr_q <= maddr_d;
    end
  end

  // Full is only needed inside the stack for count saturation.
  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (unused_ras_full)
  );

  assign pc            = pc_q;
  assign pc_valid      = valid_q;
  assign misalign      = mis_q;
  assign misalign_addr = maddr_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised next-generation program-counter generator for the Saratoga Fetch Stage. It replaces the single-override PC register with:
- N prioritised redirect channels (trap, branch, jump, ...), where a redirect overrides a fetch stall;
- optional 16-bit instruction alignment (compressed-instruction support);
- misaligned-redirect detection;
- a small return-address stack (RAS) for predicting returns.

It sits between the redirect sources in Execute/trap logic and the instruction-fetch address port.

## Interface
Parameters:
- RESET_ADDR, DEFAULT_RESET_ADDR, PC value loaded on reset
- XLEN, 32, address width
- NUM_REDIRECT, 3, number of redirect channels; index 0 has highest priority
- RAS_DEPTH, 4, RAS entries (power of two, ≥2)
- IALIGN, 32, instruction alignment in bits; 16 or 32 only

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- stall_fetch  in  1  hold PC (sequential/predicted advance only)
- redirect_en  in  NUM_REDIRECT  per-channel redirect request
- redirect_pc  in  NUM_REDIRECT×XLEN  per-channel target
- inst_len16  in  1  current instruction is 16-bit (ignored when IALIGN=32)
- call  in  1  predecoded call at pc; push return address
- ret  in  1  predecoded return at pc; predict from RAS
- pc  out  XLEN  current program counter
- pc_valid  out  1  pc is a fetchable address
- misalign  out  1  one-cycle pulse: accepted redirect target misaligned
- misalign_addr  out  XLEN  raw misaligned target, held until next misalign
- ras_empty  out  1  RAS holds no entries

## Operation
- Reset values:
  - pc=RESET_ADDR, pc_valid=0, misalign=0, misalign_addr=0
  - RAS count=0, RAS top pointer=0, ras_empty=1
- The first cycle after rst_n rises sets pc_valid=1. pc_valid stays 1 until the next reset.
- step = 2 if (IALIGN==16 && inst_len16), else 4. Define seq = pc+step, wrapping mod 2^XLEN.
- Next-PC priority, evaluated every cycle; the first match wins:
  1. Any redirect_en[i]: take the lowest asserted index. pc ← target with low log2(IALIGN/8) bits cleared. This applies even when stall_fetch=1. No RAS operation.
  2. stall_fetch=1: pc holds. No RAS operation.
  3. ret=1 and RAS non-empty: pc ← RAS top, then pop. If call is also 1, push seq after the pop; count is unchanged and the top is replaced.
  4. Otherwise: pc ← seq. If call=1, push seq. ret with an empty RAS falls here (sequential fetch).
- Misalign: when the accepted redirect target has (target mod IALIGN/8)≠0, pulse misalign=1 for one cycle and set misalign_addr=target (raw). pc still loads the aligned address. The trap unit issues the follow-up redirect.
- RAS behaviour:
  - Circular buffer. Push increments the top pointer (mod RAS_DEPTH) and writes the entry. count saturates at RAS_DEPTH; pushing when full overwrites the oldest entry.
  - Pop decrements the pointer and count.
  - The RAS is not repaired on redirect; a mispredicted return is corrected by a later redirect.
- Reset during operation: all state returns to reset values on the next edge, regardless of other inputs.

## Timing
- All outputs are registered.
- An input sampled at edge k is reflected on pc after edge k; latency is 1 cycle.
- The RAS top value used by ret is the registered content before the edge. A push and a predict in the same cycle do not bypass.
- misalign is high exactly the cycle after the redirect is accepted.
- ras_empty is updated in the same cycle as count.

## Structure
- Shared saratoga package:
  - DEFAULT_RESET_ADDR (already present)
  - new constant IALIGN_DEFAULT=32
  - typedef ras_ptr_t sized by RAS_DEPTH, via function clog2 use in module
- Sub-module pc_ras: circular stack with push, pop, push_data, top, empty, full ports. pc_gen holds the priority mux, alignment and misalign logic.
- Redirect priority encoder inline (for-loop from highest index down to 0).

## Test plan
- Reset, then no stall/redirect, RESET_ADDR=0x0000_1000 → pc 0x1000, 0x1004, 0x1008; pc_valid 0 then 1.
- stall_fetch=1 with redirect_en=3'b110, targets ch1=0x200, ch2=0x300 → pc=0x200 next cycle. Then release the redirect while the stall stays → pc holds 0x200.
- IALIGN=16, pc=0x100, inst_len16=1 → 0x102. Then inst_len16=0 → 0x106. With IALIGN=32, redirect to 0x402 → pc=0x400, misalign pulse one cycle, misalign_addr=0x402.
- RAS_DEPTH=4:
  - At pc=0x10 with call → push 0x14. Later ret at any pc → next pc 0x14, ras_empty=1.
  - With the RAS empty, ret → pc+4.
- Five calls at pcs 0x0,0x10,0x20,0x30,0x40 → four rets predict 0x44,0x34,0x24,0x14 (0x4 overwritten). Fifth ret → sequential.
- pc=0xFFFF_FFFC sequential → 0x0000_0000. Drop rst_n mid-sequence with call/redirect active → pc=RESET_ADDR, ras_empty=1, misalign=0.
